// File: rtl/sipo_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_receiver_if
// Brief    : Valid/ready word holding-register bus out of the frame receiver.
// Revision : 1.0
// ============================================================================
interface sipo_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/sipo_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_receiver
// Brief    : Serial-in/parallel-out frame receiver with valid/ready output,
//            sticky overrun flag and frame-abort pulse.
// Revision : 1.0
// ============================================================================
module sipo_frame_receiver #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit CONTINUOUS = 1'b0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             ser_in,
    input  wire logic             shift_en,
    input  wire logic             frame_start,
    sipo_frame_receiver_if.master out_if,
    output logic [WIDTH-1:0]      shift_q,
    output logic                  busy,
    output logic                  overrun,
    input  wire logic             ovr_clr,
    output logic                  frame_abort
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [WIDTH-1:0] r_shift_q;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_shift_base;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_abort;
    logic             w_do_shift;
    logic             w_complete;
    logic             w_abort;
    logic             w_accept;
    logic             w_drop;

    // A frame_start restarts from an empty register, so the same-cycle bit
    // is shifted into zeros rather than into the stale partial frame.
    assign w_shift_base = frame_start ? '0 : r_shift_q;
    assign w_cnt_base   = frame_start ? '0 : r_bit_cnt;
    assign w_do_shift   = shift_en && (frame_start || (r_state == SHIFT));
    assign w_complete   = w_do_shift && (w_cnt_base == c_last_bit);
    assign w_abort      = frame_start && (r_state == SHIFT) && (r_bit_cnt != '0);
    assign w_accept     = w_complete && (!r_out_valid || out_if.out_ready);
    assign w_drop       = w_complete && r_out_valid && !out_if.out_ready;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {w_shift_base[WIDTH-2:0], ser_in};
        end else begin : g_lsb_first
            assign w_shifted = {ser_in, w_shift_base[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift_q;
        if (frame_start) begin
            w_state_nxt   = SHIFT;
            w_bit_cnt_nxt = '0;
            w_shift_nxt   = '0;
        end
        if (w_do_shift) begin
            w_shift_nxt   = w_shifted;
            w_bit_cnt_nxt = w_complete ? '0 : (w_cnt_base + CNT_W'(1));
        end
        if (w_complete) begin
            w_state_nxt = CONTINUOUS ? SHIFT : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_shift_q     <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift_q     <= w_shift_nxt;
            r_frame_abort <= w_abort;
            // A completion with a same-cycle consume replaces the word in place.
            if (w_accept) begin
                r_out_data  <= w_shifted;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_if.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_if.out_data  = r_out_data;
    assign out_if.out_valid = r_out_valid;
    assign shift_q          = r_shift_q;
    assign busy             = (r_state == SHIFT);
    assign overrun          = r_overrun;
    assign frame_abort      = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_frame_receiver
// Brief    : Scoreboard bench for sipo_frame_receiver (MSB/LSB/continuous).
// Revision : 1.0
// ============================================================================
module tb_sipo_frame_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ser_in = 1'b0, shift_en = 1'b0, frame_start = 1'b0;
    logic out_ready = 1'b0, ovr_clr = 1'b0;
    logic c_ser = 1'b0, c_en = 1'b0, c_start = 1'b0;

    logic [7:0] sq_a, sq_b, sq_c;
    logic busy_a, busy_b, busy_c;
    logic ovr_a, ovr_b, ovr_c;
    logic abt_a, abt_b, abt_c;

    int tests = 0;
    int fails = 0;

    sipo_frame_receiver_if #(.WIDTH(8)) if_a ();
    sipo_frame_receiver_if #(.WIDTH(8)) if_b ();
    sipo_frame_receiver_if #(.WIDTH(8)) if_c ();

    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = 1'b1;

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0)) dut_a (
        .clk(clk), .rst(rst), .ser_in(ser_in), .shift_en(shift_en),
        .frame_start(frame_start), .out_if(if_a), .shift_q(sq_a), .busy(busy_a),
        .overrun(ovr_a), .ovr_clr(ovr_clr), .frame_abort(abt_a));

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ser_in(ser_in), .shift_en(shift_en),
        .frame_start(frame_start), .out_if(if_b), .shift_q(sq_b), .busy(busy_b),
        .overrun(ovr_b), .ovr_clr(ovr_clr), .frame_abort(abt_b));

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1)) dut_c (
        .clk(clk), .rst(rst), .ser_in(c_ser), .shift_en(c_en),
        .frame_start(c_start), .out_if(if_c), .shift_q(sq_c), .busy(busy_c),
        .overrun(ovr_c), .ovr_clr(1'b0), .frame_abort(abt_c));

    // Expected words per DUT, in presentation order.
    logic [7:0] q [3][$];
    bit         pres [3];
    logic       mv [3];
    logic       mr [3];
    logic [7:0] md [3];

    assign mv[0] = if_a.out_valid;  assign mr[0] = if_a.out_ready;  assign md[0] = if_a.out_data;
    assign mv[1] = if_b.out_valid;  assign mr[1] = if_b.out_ready;  assign md[1] = if_b.out_data;
    assign mv[2] = if_c.out_valid;  assign mr[2] = if_c.out_ready;  assign md[2] = if_c.out_data;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A new word is presented when valid is seen without an outstanding one;
    // a handshake at the coming edge makes the next valid a fresh word.
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    pres[k] = 1'b0;
                end else begin
                    if (mv[k] && !pres[k]) begin
                        tests++;
                        if (q[k].size() == 0) begin
                            fails++;
                            $display("FAIL word_dut%0d: got %0h expected no word", k, md[k]);
                        end else begin
                            exp = q[k].pop_front();
                            if (md[k] !== exp) begin
                                fails++;
                                $display("FAIL word_dut%0d: got %0h expected %0h", k, md[k], exp);
                            end
                        end
                        pres[k] = 1'b1;
                    end
                    if (mv[k] && mr[k]) pres[k] = 1'b0;
                end
            end
        end
    end

    task automatic step(input logic s, input logic e, input logic f);
        ser_in = s; shift_en = e; frame_start = f;
        @(posedge clk); #1;
        ser_in = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] w);
        q[0].push_back(w);
        q[1].push_back(rev8(w));
    endtask

    task automatic send_frame(input logic [7:0] w, input bit gaps, input bit chk_abort,
                              input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            out_ready = rdy_last && (i == 7);
            step(w[7-i], 1'b1, i == 0);
            out_ready = 1'b0;
            if (chk_abort && i == 0) check("abort_pulse", abt_a, 1);
            if (chk_abort && i == 1) check("abort_single", abt_a, 0);
            if (gaps && i < 7) begin
                step(1'b1, 1'b0, 1'b0);
                check("gap_hold", sq_a, w >> (7 - i));
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        check("consumed_valid", if_a.out_valid, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  if_a.out_data, 0);
        check({tag, "_valid"}, if_a.out_valid, 0);
        check({tag, "_shq"},   sq_a, 0);
        check({tag, "_busy"},  busy_a, 0);
        check({tag, "_ovr"},   ovr_a, 0);
        check({tag, "_abort"}, abt_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Basic frame: CD for MSB-first, B3 for LSB-first.
        expect_word(8'hCD);
        send_frame(8'hCD, 1'b0, 1'b0, 1'b0);
        check("t1_busy_after", busy_a, 0);
        check("t1_valid", if_a.out_valid, 1);
        check("t1_shq_final", sq_a, 8'hCD);
        consume();

        // Alternate-cycle gaps.
        expect_word(8'hCD);
        send_frame(8'hCD, 1'b1, 1'b0, 1'b0);
        consume();

        // Overrun: second word dropped while first pending.
        expect_word(8'hCD);
        send_frame(8'hCD, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("t4_overrun", ovr_a, 1);
        check("t4_keep_old", if_a.out_data, 8'hCD);
        check("t4_overrun_b", ovr_b, 1);
        ovr_clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        ovr_clr = 1'b0;
        check("t4_ovr_clr", ovr_a, 0);
        // Same-cycle consume replaces the pending word.
        expect_word(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("t4_no_overrun", ovr_a, 0);
        check("t4_valid_kept", if_a.out_valid, 1);
        consume();

        // Abort after 3 bits, then a full A5 frame.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("t5_busy_mid", busy_a, 1);
        expect_word(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        consume();

        // Reset mid-frame discards silently.
        step(1'b1, 1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check_zero("midrst");
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check("midrst_abort_after", abt_a, 0);
        check("midrst_idle_ignores", sq_a, 0);

        // Continuous mode: 01 then FF with one frame_start.
        q[2].push_back(8'h01);
        q[2].push_back(8'hFF);
        for (int i = 0; i < 16; i++) begin
            c_ser   = (i < 8) ? (i == 7) : 1'b1;
            c_en    = 1'b1;
            c_start = (i == 0);
            @(posedge clk); #1;
        end
        c_ser = 1'b0; c_en = 1'b0; c_start = 1'b0;
        check("t6_overrun", ovr_c, 0);
        check("t6_busy", busy_c, 1);
        check("t6_shq", sq_c, 8'hFF);

        repeat (3) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) check("queue_drained", q[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
